// File: rtl/signal_debouncer.sv
// Conditions a raw asynchronous level: synchronises it, then accepts a new level only after
// DEBOUNCE_CYCLES consecutive matching samples. Shorter candidates are counted as glitches.
module signal_debouncer #(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned GLITCH_W        = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                signal_raw,
   output logic                signal_clean,
   output logic                busy,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   localparam int unsigned     CntW    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   typedef enum logic [1:0] {
      StStableLo,
      StWaitHi,
      StStableHi,
      StWaitLo
   } state_e;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   state_e                 state_q;
   logic [CntW-1:0]        cnt_q;
   logic                   glitch_sat;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], signal_raw};
      end
   end

   assign sync_out   = sync_q[SYNC_STAGES-1];
   assign glitch_sat = &glitch_cnt;

   // cnt_q holds the number of consecutive new-level samples seen so far.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StStableLo;
         cnt_q        <= '0;
         signal_clean <= 1'b0;
         busy         <= 1'b0;
         glitch_cnt   <= '0;
      end else begin
         unique case (state_q)
            StStableLo: begin
               if (sync_out) begin
                  state_q <= StWaitHi;
                  cnt_q   <= CntOne;
                  busy    <= 1'b1;
               end
            end
            StWaitHi: begin
               if (sync_out) begin
                  if (cnt_q == CntLast) begin
                     state_q      <= StStableHi;
                     signal_clean <= 1'b1;
                     cnt_q        <= '0;
                     busy         <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + CntOne;
                  end
               end else begin
                  state_q <= StStableLo;
                  cnt_q   <= '0;
                  busy    <= 1'b0;
                  if (!glitch_sat) glitch_cnt <= glitch_cnt + GLITCH_W'(1);
               end
            end
            StStableHi: begin
               if (!sync_out) begin
                  state_q <= StWaitLo;
                  cnt_q   <= CntOne;
                  busy    <= 1'b1;
               end
            end
            StWaitLo: begin
               if (!sync_out) begin
                  if (cnt_q == CntLast) begin
                     state_q      <= StStableLo;
                     signal_clean <= 1'b0;
                     cnt_q        <= '0;
                     busy         <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + CntOne;
                  end
               end else begin
                  state_q <= StStableHi;
                  cnt_q   <= '0;
                  busy    <= 1'b0;
                  if (!glitch_sat) glitch_cnt <= glitch_cnt + GLITCH_W'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_signal_debouncer.sv
// Bench for signal_debouncer: directed vector table, reset/saturation sequences, and random
// run-length stimulus checked against a run-length model of the debounce rules.
`timescale 1ns/1ps
module tb_signal_debouncer;

   localparam int unsigned SYNC = 2;
   localparam int unsigned DEB  = 4;
   localparam int unsigned GW   = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          signal_raw = 1'b0;
   logic          signal_clean;
   logic          busy;
   logic [GW-1:0] glitch_cnt;

   int total = 0;
   int bad   = 0;

   signal_debouncer #(
      .SYNC_STAGES    (SYNC),
      .DEBOUNCE_CYCLES(DEB),
      .GLITCH_W       (GW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .signal_raw  (signal_raw),
      .signal_clean(signal_clean),
      .busy        (busy),
      .glitch_cnt  (glitch_cnt)
   );

   always #5 clk = ~clk;

   // Reference: the level seen after SYNC edges of delay, and the length of the current
   // run of samples that disagree with the accepted level.
   logic          m_q[$];
   int unsigned   m_run;
   logic          m_clean;
   logic [GW-1:0] m_glitch;

   task automatic model_reset();
      m_run    = 0;
      m_clean  = 1'b0;
      m_glitch = '0;
      m_q.delete();
      for (int i = 0; i < SYNC; i++) m_q.push_back(1'b0);
   endtask

   task automatic model_edge(input logic raw);
      logic s;
      s = m_q.pop_front();
      m_q.push_back(raw);
      if (s != m_clean) begin
         m_run++;
         if (m_run == DEB) begin
            m_clean = s;
            m_run   = 0;
         end
      end else begin
         if (m_run != 0 && m_glitch != '1) m_glitch++;
         m_run = 0;
      end
   endtask

   task automatic check_all(input string name, input logic c, input logic b,
                            input logic [GW-1:0] g);
      total++;
      if (signal_clean !== c || busy !== b || glitch_cnt !== g) begin
         bad++;
         $display("FAIL %s @%0t: got clean=%0b busy=%0b glitch=%0d, want clean=%0b busy=%0b glitch=%0d",
                  name, $time, signal_clean, busy, glitch_cnt, c, b, g);
      end
   endtask

   typedef struct {
      logic          raw;
      logic          clean;
      logic          busy;
      logic [GW-1:0] glitch;
   } vec_t;

   vec_t vecs[25];

   initial begin
      logic          prev_clean;
      logic [GW-1:0] prev_g;
      int            last_chg;
      int unsigned   remaining;
      logic          lvl;

      // Rise accepted after SYNC+DEB edges; 3-sample low glitch; 4-sample fall accepted;
      // 3-sample high glitch.
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'd0}; vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'd0};
      vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'd0}; vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'd0};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 8'd0}; vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'd0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'd0}; vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'd0};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'd0}; vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'd0};
      vecs[10] = '{1'b1, 1'b1, 1'b1, 8'd0}; vecs[11] = '{1'b1, 1'b1, 1'b0, 8'd1};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 8'd1}; vecs[13] = '{1'b0, 1'b1, 1'b0, 8'd1};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 8'd1}; vecs[15] = '{1'b0, 1'b1, 1'b1, 8'd1};
      vecs[16] = '{1'b0, 1'b1, 1'b1, 8'd1}; vecs[17] = '{1'b0, 1'b0, 1'b0, 8'd1};
      vecs[18] = '{1'b1, 1'b0, 1'b0, 8'd1}; vecs[19] = '{1'b1, 1'b0, 1'b0, 8'd1};
      vecs[20] = '{1'b1, 1'b0, 1'b1, 8'd1}; vecs[21] = '{1'b0, 1'b0, 1'b1, 8'd1};
      vecs[22] = '{1'b0, 1'b0, 1'b1, 8'd1}; vecs[23] = '{1'b0, 1'b0, 1'b0, 8'd2};
      vecs[24] = '{1'b0, 1'b0, 1'b0, 8'd2};

      // Reset acts before any clock edge.
      #2;
      check_all("reset_state", 1'b0, 1'b0, 8'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 25; i++) begin
         signal_raw = vecs[i].raw;
         @(posedge clk); #1;
         check_all($sformatf("vec%0d", i), vecs[i].clean, vecs[i].busy, vecs[i].glitch);
      end

      // Asynchronous reset in the middle of a high candidate.
      signal_raw = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check_all("pre_rst_wait_hi", 1'b0, 1'b1, 8'd2);
      #3 rst = 1'b1;
      #1 check_all("async_rst_wait_hi", 1'b0, 1'b0, 8'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         check_all($sformatf("post_rst_edge%0d", k), (k == 6), (k >= 3 && k <= 5), 8'd0);
      end

      // Asynchronous reset while the clean level is high.
      #3 rst = 1'b1;
      #1 check_all("async_rst_clean_hi", 1'b0, 1'b0, 8'd0);
      signal_raw = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;

      // 12 ns toggling: every high pulse spans at most two samples.
      prev_g = '0;
      fork
         begin
            repeat (833) #12 signal_raw = ~signal_raw;
         end
         begin
            for (int c = 0; c < 1000; c++) begin
               @(posedge clk); #1;
               total++;
               if (signal_clean !== 1'b0) begin
                  bad++;
                  $display("FAIL toggle_clean cyc%0d: got %0b, want 0", c, signal_clean);
               end
               total++;
               if (glitch_cnt < prev_g) begin
                  bad++;
                  $display("FAIL toggle_no_wrap cyc%0d: got %0d after %0d", c, glitch_cnt, prev_g);
               end
               prev_g = glitch_cnt;
            end
         end
      join
      check_all("glitch_saturated", 1'b0, busy, 8'hFF);

      // Random run lengths against the model, with occasional mid-cycle resets.
      rst        = 1'b1;
      signal_raw = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      prev_clean = 1'b0;
      last_chg   = -100;
      remaining  = 0;
      lvl        = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (remaining == 0) begin
            lvl       = ~lvl;
            remaining = $urandom_range(1, 7);
         end
         signal_raw = lvl;
         remaining--;
         if ($urandom_range(0, 399) == 0) begin
            #2 rst = 1'b1;
            #2 rst = 1'b0;
            model_reset();
            prev_clean = 1'b0;
            last_chg   = -100;
            check_all("rnd_reset", 1'b0, 1'b0, 8'd0);
         end
         model_edge(signal_raw);
         @(posedge clk); #1;
         check_all($sformatf("rnd%0d", cyc), m_clean, (m_run != 0), m_glitch);
         if (signal_clean !== prev_clean) begin
            total++;
            if (cyc - last_chg < int'(DEB)) begin
               bad++;
               $display("FAIL clean_spacing cyc%0d: got %0d cycles since last change, want >= %0d",
                        cyc, cyc - last_chg, DEB);
            end
            last_chg   = cyc;
            prev_clean = signal_clean;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
